// File: rtl/stack_controller_pkg.sv
// Shared encodings and geometry defaults for the burger-stacking game.
// The draw block imports the same geometry so both sides agree on layer sizes.
package stack_controller_pkg;

    localparam int DEF_HEIGHT_RATIO = 20;
    localparam int DEF_WIDTH        = 150;
    localparam int DEF_BASE_Y       = 400;

    localparam logic [31:0] COLORS_RESET = 32'h0000_0001;

    typedef enum logic [1:0] {
        COL_EMPTY = 2'b00,
        COL_GREEN = 2'b01,
        COL_RED   = 2'b10,
        COL_BLUE  = 2'b11
    } color_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_FALL,
        ST_CHECK,
        ST_OVER,
        ST_WIN
    } state_e;

endpackage

// File: rtl/stack_controller_if.sv
// Player/frame inputs and renderer-facing outputs of the stack sequencer.
// master drives the inputs (debouncers, divider); slave is the sequencer itself.
interface stack_controller_if;
    import stack_controller_pkg::*;

    logic        tick;
    logic        start;
    logic        fast_drop;
    logic [9:0]  pos_x;
    logic [31:0] colors;
    logic [3:0]  height;
    logic [9:0]  fall_x;
    logic [9:0]  fall_y;
    color_e      fall_color;
    logic        fall_valid;
    logic [1:0]  lives;
    logic        game_over;
    logic        game_win;

    modport master (
        output tick, start, fast_drop, pos_x,
        input  colors, height, fall_x, fall_y, fall_color, fall_valid,
               lives, game_over, game_win
    );

    modport slave (
        input  tick, start, fast_drop, pos_x,
        output colors, height, fall_x, fall_y, fall_color, fall_valid,
               lives, game_over, game_win
    );
endinterface

// File: rtl/stack_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting, feedback into the MSB.
module stack_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);
    logic [15:0] lfsr_q, lfsr_d;
    logic        fb;

    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = en_i ? {fb, lfsr_q[15:1]} : lfsr_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/stack_controller.sv
// Game sequencer: spawns a falling ingredient, drops it per frame tick, and
// commits catch/miss into the packed stack word, height and lives.
module stack_controller
    import stack_controller_pkg::*;
#(
    parameter int          HEIGHT_RATIO = DEF_HEIGHT_RATIO,
    parameter int          WIDTH        = DEF_WIDTH,
    parameter int          BASE_Y       = DEF_BASE_Y,
    parameter int          SPAWN_Y      = 0,
    parameter int          FALL_STEP    = 4,
    parameter int          FAST_MUL     = 4,
    parameter int          X_MAX        = 490,
    parameter int          LIVES        = 3,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input logic               clk_i,
    input logic               rst_ni,
    stack_controller_if.slave bus
);
    localparam logic [10:0] HR         = 11'(HEIGHT_RATIO);
    localparam logic [10:0] WD         = 11'(WIDTH);
    localparam logic [10:0] BY         = 11'(BASE_Y);
    localparam logic [9:0]  SY         = 10'(SPAWN_Y);
    localparam logic [10:0] STEP_SLOW  = 11'(FALL_STEP);
    localparam logic [10:0] STEP_FAST  = 11'(FALL_STEP * FAST_MUL);
    localparam logic [9:0]  XMAX       = 10'(X_MAX);
    localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

    state_e      state_q, state_d;
    logic [31:0] colors_q, colors_d;
    logic [3:0]  height_q, height_d;
    logic [9:0]  fall_x_q, fall_x_d;
    logic [9:0]  fall_y_q, fall_y_d;
    color_e      fall_color_q, fall_color_d;
    logic        fall_valid_q, fall_valid_d;
    logic [1:0]  lives_q, lives_d;
    logic        over_q, over_d;
    logic        win_q, win_d;

    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;
    logic [10:0] catch_line;
    logic [10:0] new_y;
    logic [9:0]  raw_x;
    logic [4:0]  slot_lsb;
    logic        overlap;

    stack_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (1'b1),
        .lfsr_o (lfsr_q)
    );

    assign unused_lfsr_bits = ^lfsr_q[15:11];

    always_comb begin
        state_d      = state_q;
        colors_d     = colors_q;
        height_d     = height_q;
        fall_x_d     = fall_x_q;
        fall_y_d     = fall_y_q;
        fall_color_d = fall_color_q;
        fall_valid_d = fall_valid_q;
        lives_d      = lives_q;
        over_d       = over_q;
        win_d        = win_q;

        catch_line = BY - (11'(height_q) * HR);
        new_y      = 11'(fall_y_q) + (bus.fast_drop ? STEP_FAST : STEP_SLOW);
        raw_x      = 10'(lfsr_q[8:0]);
        slot_lsb   = {height_q + 4'd1, 1'b0};
        overlap    = (11'(fall_x_q) < 11'(bus.pos_x) + WD) &&
                     (11'(bus.pos_x) < 11'(fall_x_q) + WD);

        unique case (state_q)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (bus.start) begin
                    colors_d = COLORS_RESET;
                    height_d = 4'd0;
                    lives_d  = LIVES_INIT;
                    over_d   = 1'b0;
                    win_d    = 1'b0;
                    state_d  = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                // Out-of-range x folds back by 256 so every LFSR value yields a legal spawn.
                fall_x_d     = (raw_x <= XMAX) ? raw_x : raw_x - 10'd256;
                fall_color_d = (lfsr_q[10:9] == 2'b00) ? COL_RED : color_e'(lfsr_q[10:9]);
                fall_y_d     = SY;
                fall_valid_d = 1'b1;
                state_d      = ST_FALL;
            end
            ST_FALL: begin
                if (bus.tick) begin
                    if (new_y + HR >= catch_line) begin
                        fall_y_d = 10'(catch_line - HR);
                        state_d  = ST_CHECK;
                    end else begin
                        fall_y_d = new_y[9:0];
                    end
                end
            end
            ST_CHECK: begin
                fall_valid_d = 1'b0;
                if (overlap) begin
                    colors_d[slot_lsb +: 2] = fall_color_q;
                    height_d                = height_q + 4'd1;
                    if (height_d == 4'd15) begin
                        win_d   = 1'b1;
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_SPAWN;
                    end
                end else begin
                    lives_d = lives_q - 2'd1;
                    if (lives_d == 2'd0) begin
                        over_d  = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_SPAWN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            colors_q     <= COLORS_RESET;
            height_q     <= 4'd0;
            fall_x_q     <= 10'd0;
            fall_y_q     <= 10'd0;
            fall_color_q <= COL_EMPTY;
            fall_valid_q <= 1'b0;
            lives_q      <= LIVES_INIT;
            over_q       <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            colors_q     <= colors_d;
            height_q     <= height_d;
            fall_x_q     <= fall_x_d;
            fall_y_q     <= fall_y_d;
            fall_color_q <= fall_color_d;
            fall_valid_q <= fall_valid_d;
            lives_q      <= lives_d;
            over_q       <= over_d;
            win_q        <= win_d;
        end
    end

    assign bus.colors     = colors_q;
    assign bus.height     = height_q;
    assign bus.fall_x     = fall_x_q;
    assign bus.fall_y     = fall_y_q;
    assign bus.fall_color = fall_color_q;
    assign bus.fall_valid = fall_valid_q;
    assign bus.lives      = lives_q;
    assign bus.game_over  = over_q;
    assign bus.game_win   = win_q;
endmodule
